// File: rtl/rs_station_param_if.sv
// Dispatch, CDB broadcast and issue handshake bundle for the reservation station.
// master = dispatcher/CDB/execution side, slave = the station itself.
interface rs_station_param_if #(
    parameter int RS_DEPTH = 16,
    parameter int ROBIDBW  = 4,
    parameter int NUM_CDB  = 2
) ();
    localparam int CW = $clog2(RS_DEPTH) + 1;

    logic                     disp_valid;
    logic [5:0]               disp_op;
    logic [31:0]              disp_pc;
    logic [31:0]              disp_imm;
    logic [ROBIDBW-1:0]       disp_rob;
    logic                     disp_q1_busy;
    logic [ROBIDBW-1:0]       disp_q1;
    logic [31:0]              disp_v1;
    logic                     disp_q2_busy;
    logic [ROBIDBW-1:0]       disp_q2;
    logic [31:0]              disp_v2;
    logic                     rs_full;
    logic [CW-1:0]            count;

    logic [NUM_CDB-1:0]         cdb_valid;
    logic [NUM_CDB*ROBIDBW-1:0] cdb_rob;
    logic [NUM_CDB*32-1:0]      cdb_val;

    logic                     issue_valid;
    logic                     issue_ready;
    logic [5:0]               issue_op;
    logic [31:0]              issue_pc;
    logic [31:0]              issue_imm;
    logic [31:0]              issue_v1;
    logic [31:0]              issue_v2;
    logic [ROBIDBW-1:0]       issue_rob;

    modport master (
        output disp_valid, disp_op, disp_pc, disp_imm, disp_rob,
               disp_q1_busy, disp_q1, disp_v1, disp_q2_busy, disp_q2, disp_v2,
               cdb_valid, cdb_rob, cdb_val, issue_ready,
        input  rs_full, count, issue_valid, issue_op, issue_pc, issue_imm,
               issue_v1, issue_v2, issue_rob
    );

    modport slave (
        input  disp_valid, disp_op, disp_pc, disp_imm, disp_rob,
               disp_q1_busy, disp_q1, disp_v1, disp_q2_busy, disp_q2, disp_v2,
               cdb_valid, cdb_rob, cdb_val, issue_ready,
        output rs_full, count, issue_valid, issue_op, issue_pc, issue_imm,
               issue_v1, issue_v2, issue_rob
    );
endinterface

// File: rtl/rs_station_param.sv
// Parameterized reservation station: CDB wakeup with dispatch bypass, oldest-ready
// selection via an age matrix, and a one-deep registered issue slot.
module rs_station_param #(
    parameter int RS_DEPTH = 16,
    parameter int ROBIDBW  = 4,
    parameter int NUM_CDB  = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    rs_station_param_if.slave bus
);
    localparam int IW = $clog2(RS_DEPTH);
    localparam int CW = IW + 1;

    typedef logic [ROBIDBW-1:0] tag_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] pc;
        logic [31:0] imm;
        tag_t        rob;
        logic        q1b;
        tag_t        q1;
        logic [31:0] v1;
        logic        q2b;
        tag_t        q2;
        logic [31:0] v2;
    } ent_t;

    ent_t                ent [RS_DEPTH];
    logic [RS_DEPTH-1:0] busy;
    // age[i][j] set means entry i is older than entry j
    logic [RS_DEPTH-1:0] age [RS_DEPTH];
    logic [CW-1:0]       cnt;
    logic                iss_vld;
    ent_t                iss;

    logic [NUM_CDB-1:0]               cv;
    logic [NUM_CDB-1:0][ROBIDBW-1:0]  crob;
    logic [NUM_CDB-1:0][31:0]         cval;

    assign cv   = bus.cdb_valid;
    assign crob = bus.cdb_rob;
    assign cval = bus.cdb_val;

    logic [RS_DEPTH-1:0] hit1, hit2;
    logic [31:0]         wv1 [RS_DEPTH];
    logic [31:0]         wv2 [RS_DEPTH];
    logic                dh1, dh2;
    logic [31:0]         dv1, dv2;

    // Channels scanned high to low so the lowest matching channel is written last.
    always_comb begin
        hit1 = '0;
        hit2 = '0;
        dh1  = 1'b0;
        dh2  = 1'b0;
        dv1  = bus.disp_v1;
        dv2  = bus.disp_v2;
        for (int i = 0; i < RS_DEPTH; i++) begin
            wv1[i] = ent[i].v1;
            wv2[i] = ent[i].v2;
        end
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cv[k]) begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (busy[i] && ent[i].q1b && ent[i].q1 == crob[k]) begin
                        hit1[i] = 1'b1;
                        wv1[i]  = cval[k];
                    end
                    if (busy[i] && ent[i].q2b && ent[i].q2 == crob[k]) begin
                        hit2[i] = 1'b1;
                        wv2[i]  = cval[k];
                    end
                end
                if (bus.disp_q1_busy && bus.disp_q1 == crob[k]) begin
                    dh1 = 1'b1;
                    dv1 = cval[k];
                end
                if (bus.disp_q2_busy && bus.disp_q2 == crob[k]) begin
                    dh2 = 1'b1;
                    dv2 = cval[k];
                end
            end
        end
    end

    logic [RS_DEPTH-1:0] ready;
    logic                sel_vld;
    logic [IW-1:0]       sel_idx;
    logic [IW-1:0]       free_idx;
    logic                blk;

    always_comb begin
        ready    = '0;
        sel_vld  = 1'b0;
        sel_idx  = '0;
        free_idx = '0;
        blk      = 1'b0;
        for (int i = 0; i < RS_DEPTH; i++)
            ready[i] = busy[i] & ~ent[i].q1b & ~ent[i].q2b;
        for (int i = RS_DEPTH - 1; i >= 0; i--)
            if (!busy[i]) free_idx = IW'(i);
        for (int i = 0; i < RS_DEPTH; i++) begin
            blk = 1'b0;
            for (int j = 0; j < RS_DEPTH; j++)
                if (ready[j] && age[j][i]) blk = 1'b1;
            if (ready[i] && !blk) begin
                sel_vld = 1'b1;
                sel_idx = IW'(i);
            end
        end
    end

    logic rs_full, accept, move;

    assign rs_full = (cnt == CW'(RS_DEPTH));
    assign accept  = bus.disp_valid && !rs_full && rdy_in && !flush_in;
    assign move    = sel_vld && (!iss_vld || bus.issue_ready);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy    <= '0;
            cnt     <= '0;
            iss_vld <= 1'b0;
            iss     <= '0;
            for (int i = 0; i < RS_DEPTH; i++) age[i] <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                busy    <= '0;
                cnt     <= '0;
                iss_vld <= 1'b0;
                for (int i = 0; i < RS_DEPTH; i++) age[i] <= '0;
            end else begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (hit1[i]) begin
                        ent[i].q1b <= 1'b0;
                        ent[i].v1  <= wv1[i];
                    end
                    if (hit2[i]) begin
                        ent[i].q2b <= 1'b0;
                        ent[i].v2  <= wv2[i];
                    end
                end
                if (move) begin
                    busy[sel_idx] <= 1'b0;
                    iss           <= ent[sel_idx];
                    iss_vld       <= 1'b1;
                    for (int j = 0; j < RS_DEPTH; j++) begin
                        age[sel_idx][j] <= 1'b0;
                        age[j][sel_idx] <= 1'b0;
                    end
                end else if (iss_vld && bus.issue_ready) begin
                    iss_vld <= 1'b0;
                end
                if (accept) begin
                    busy[free_idx] <= 1'b1;
                    ent[free_idx]  <= '{op: bus.disp_op, pc: bus.disp_pc, imm: bus.disp_imm,
                                       rob: bus.disp_rob,
                                       q1b: bus.disp_q1_busy && !dh1, q1: bus.disp_q1, v1: dv1,
                                       q2b: bus.disp_q2_busy && !dh2, q2: bus.disp_q2, v2: dv2};
                    for (int j = 0; j < RS_DEPTH; j++) begin
                        age[free_idx][j] <= 1'b0;
                        age[j][free_idx] <= busy[j] && !(move && sel_idx == IW'(j));
                    end
                end
                cnt <= cnt + CW'(accept) - CW'(move);
            end
        end
    end

    assign bus.rs_full     = rs_full;
    assign bus.count       = cnt;
    assign bus.issue_valid = iss_vld;
    assign bus.issue_op    = iss.op;
    assign bus.issue_pc    = iss.pc;
    assign bus.issue_imm   = iss.imm;
    assign bus.issue_v1    = iss.v1;
    assign bus.issue_v2    = iss.v2;
    assign bus.issue_rob   = iss.rob;
endmodule

// File: doc/rs_station_param.md
RS_STATION_PARAM -- requirements
Module: rs_station_param

Interface
REQ-001 SHALL provide parameter RS_DEPTH, default 16, number of entries (power of two, >=2).
REQ-002 SHALL provide parameter ROBIDBW, default 4, ROB tag width.
REQ-003 SHALL provide parameter NUM_CDB, default 2, number of CDB broadcast channels.
REQ-004 SHALL have port clk_in  input  1  clock; all state on rising edge.
REQ-005 SHALL have port rst_in  input  1  synchronous, active-low reset.
REQ-006 SHALL have port rdy_in  input  1  global enable; low freezes all state.
REQ-007 SHALL have port flush_in  input  1  mispredict flush.
REQ-008 SHALL have ports disp_valid 1, disp_op 6, disp_pc 32, disp_imm 32, disp_rob ROBIDBW, all inputs: dispatch request and payload.
REQ-009 SHALL have ports disp_q1_busy 1, disp_q1 ROBIDBW, disp_v1 32, all inputs: operand 1 (tag valid if busy, else value).
REQ-010 SHALL have ports disp_q2_busy, disp_q2, disp_v2, all inputs, same widths and meaning for operand 2.
REQ-011 SHALL have port rs_full  output  1  no free entry.
REQ-012 SHALL have port count  output  clog2(RS_DEPTH)+1  occupied entries.
REQ-013 SHALL have ports cdb_valid NUM_CDB, cdb_rob NUM_CDB*ROBIDBW, cdb_val NUM_CDB*32, all inputs; channel k in slice k.
REQ-014 SHALL have ports issue_valid output 1, issue_ready input 1: valid/ready handshake to execution unit.
REQ-015 SHALL have outputs issue_op 6, issue_pc 32, issue_imm 32, issue_v1 32, issue_v2 32, issue_rob ROBIDBW.

Function
REQ-016 Entry fields SHALL be busy, op, pc, imm, rob, Q1/Q2 busy+tag, V1/V2, plus an RS_DEPTH x RS_DEPTH age matrix.
REQ-017 Dispatch SHALL be accepted when disp_valid && !rs_full && rdy_in && !flush_in; disp_valid with rs_full high SHALL be ignored (dispatcher holds).
REQ-018 Accepted dispatch SHALL write the lowest-index free entry at that edge and mark it younger than all occupied entries.
REQ-019 Dispatch operand with busy tag matching a same-cycle valid CDB channel SHALL be captured as ready with that CDB value (bypass).
REQ-020 Each cycle, every occupied entry with pending Qx equal to cdb_rob[k] with cdb_valid[k] SHALL capture cdb_val[k] and clear Qx busy; lowest k wins on multiple matches.
REQ-021 Entry SHALL be ready when busy and both Q1, Q2 not busy (state after the previous edge).
REQ-022 Selection SHALL pick the oldest ready entry per age matrix; none ready -> no selection.
REQ-023 Issue output SHALL be a one-deep register; it SHALL load the selected entry when empty or when issue_valid && issue_ready in that cycle, freeing the entry at the same edge.
REQ-024 Latency: instruction dispatched at edge E with both operands ready (incl. bypass), RS otherwise empty, issue_ready high, SHALL present issue_valid after edge E+1.
REQ-025 issue_valid and payload SHALL stay stable while issue_valid && !issue_ready.
REQ-026 count SHALL update by +1 per accept, -1 per entry moved to issue register; simultaneous accept and move leaves count unchanged; rs_full = (count == RS_DEPTH).
REQ-027 A freed entry SHALL be reallocatable from the next edge, not the same edge.
REQ-028 flush_in (with rdy_in) SHALL, at the edge, clear all busy bits, the age matrix, count and issue_valid; it overrides dispatch, wakeup and issue.
REQ-029 rdy_in low SHALL hold all state and outputs unchanged regardless of other inputs.

Reset
REQ-030 rst_in low at an edge SHALL clear all busy bits, age matrix, count=0, rs_full=0, issue_valid=0, all issue payload outputs=0; priority over flush_in and rdy_in.
REQ-031 Reset asserted mid-operation SHALL discard all entries; no issue after release without new dispatch.

Verification
REQ-032 Dispatch op=5, rob=3, v1=10, v2=20, both ready, issue_ready=1 -> issue_valid after E+1 with v1=10, v2=20, rob=3; count back to 0.
REQ-033 Dispatch rob=1 with Q1=7 busy; two cycles later cdb_valid[1]=1, cdb_rob[1]=7, cdb_val[1]=0xDEAD -> issue_v1=0xDEAD one cycle after the broadcast edge.
REQ-034 Fill 16 entries with pending tags -> rs_full=1, count=16, 17th dispatch ignored; one wakeup+issue -> rs_full=0 next edge.
REQ-035 Dispatch rob=2 then rob=4 (both ready into entries 1 and 0 after frees), issue_ready=0 for 3 cycles -> rob=2 issued first and held stable, rob=4 next.
REQ-036 Dispatch with Q2=9 busy in same cycle as cdb_rob[0]=9, cdb_val=0x55 -> entry ready, issue_v2=0x55.
REQ-037 Occupy 5 entries, assert flush_in (or rst_in=0) one cycle -> count=0, issue_valid=0, no stale issue afterwards.
